// File: rtl/mux8x1_using_4x1_and_2x1_design_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared sizing constants for the hierarchical 8:1 mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  // Number of data inputs on the full mux
  localparam int N_IN       = 8;
  // Width of the full select index
  localparam int SEL_W      = 3;
  // Width of the select index seen by each 4:1 half
  localparam int HALF_SEL_W = 2;
  // Number of data inputs on each 4:1 half
  localparam int HALF_N_IN  = 1 << HALF_SEL_W;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux8x1_using_4x1_and_2x1_design_mux2x1.sv
`default_nettype none
// ============================================================================
//  Module      : mux2x1
//  Description : Combinational single-bit 2:1 multiplexer, y = s ? b : a.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2x1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  // Route b when s is high, a otherwise
  always_comb begin
    y = s ? b : a;
  end

endmodule : mux2x1
`default_nettype wire

// File: rtl/mux8x1_using_4x1_and_2x1_design_mux4x1.sv
`default_nettype none
// ============================================================================
//  Module      : mux4x1
//  Description : Combinational single-bit 4:1 multiplexer, y = i[s].
//  Revision    : 1.0 - initial release
// ============================================================================
module mux4x1
  import mux_pkg::*;
(
  input  logic [HALF_N_IN-1:0]  i,
  input  logic [HALF_SEL_W-1:0] s,
  output logic                  y
);

  // Pick the addressed bit; every select code is in range
  always_comb begin
    y = i[s];
  end

endmodule : mux4x1
`default_nettype wire

// File: rtl/mux8x1_using_4x1_and_2x1_design.sv
`default_nettype none
// ============================================================================
//  Module      : mux8x1_using_4x1_and_2x1_design
//  Description : 8:1 single-bit mux built from two 4:1 halves and a 2:1
//                final stage, with a combinational output y and a registered
//                copy y_q cleared by an asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux8x1_using_4x1_and_2x1_design
  import mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  i,
  input  logic [SEL_W-1:0] s,
  output logic             y,
  output logic             y_q
);

  logic w_lo;  // selected bit from i[3:0]
  logic w_hi;  // selected bit from i[7:4]

  // Low half: i[s[1:0]]
  mux4x1 u_mux_lo (
    .i (i[HALF_N_IN-1:0]),
    .s (s[HALF_SEL_W-1:0]),
    .y (w_lo)
  );

  // High half: i[4 + s[1:0]]
  mux4x1 u_mux_hi (
    .i (i[N_IN-1:HALF_N_IN]),
    .s (s[HALF_SEL_W-1:0]),
    .y (w_hi)
  );

  // Final stage: the top select bit chooses between the halves
  mux2x1 u_mux_out (
    .a (w_lo),
    .b (w_hi),
    .s (s[SEL_W-1]),
    .y (y)
  );

  // Registered copy of y; reset clears it without waiting for a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y;
    end
  end

endmodule : mux8x1_using_4x1_and_2x1_design
`default_nettype wire

// File: tb/tb_mux8x1_using_4x1_and_2x1_design.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux8x1_using_4x1_and_2x1_design
//  Description : Self-checking bench for the hierarchical 8:1 mux.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux8x1_using_4x1_and_2x1_design;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [7:0] i;
  logic [2:0] s;
  logic       y;
  logic       y_q;

  int n_checks;
  int n_errors;

  mux8x1_using_4x1_and_2x1_design dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .s     (s),
    .y     (y),
    .y_q   (y_q)
  );

  // 10 ns clock that can be frozen low to observe y with no clock activity
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference: bit number sel of the data word, via integer arithmetic
  function automatic logic ref_mux(input logic [7:0] v, input logic [2:0] sel);
    int word;
    int weight;
    word   = int'(v);
    weight = 1 << int'(sel);
    return ((word / weight) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (i=%b s=%0d t=%0t)", tag, got, exp, i, s, $time);
    end
  endtask

  initial begin
    logic exp_q;
    n_checks = 0;
    n_errors = 0;
    clk      = 1'b0;
    clk_en   = 1'b1;
    rst_n    = 1'b0;
    i        = 8'h00;
    s        = 3'd0;

    // Reset state, and y valid while reset is asserted
    #2;
    check("reset_y_q", y_q, 1'b0);
    i = 8'hFF;
    s = 3'd3;
    #1;
    check("y_during_reset", y, 1'b1);
    @(posedge clk); #1;
    check("y_q_held_in_reset", y_q, 1'b0);

    // Fixed pattern sweep
    i = 8'b0000_0101;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      #10;
      check("sweep_05", y, ref_mux(8'b0000_0101, 3'(k)));
    end

    // Walking one across every select value
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        i = 8'(1 << k);
        s = 3'(j);
        #1;
        check("walk_one", y, (j == k));
      end
    end

    // Upper half via s[2]
    i = 8'b1010_0000;
    s = 3'd5; #1; check("upper_s5", y, 1'b1);
    s = 3'd7; #1; check("upper_s7", y, 1'b1);
    s = 3'd4; #1; check("upper_s4", y, 1'b0);
    s = 3'd6; #1; check("upper_s6", y, 1'b0);

    // Release reset and see the first capture
    i = 8'hFF;
    s = 3'd3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("y_after_release", y, 1'b1);
    check("y_q_before_edge", y_q, 1'b0);
    @(posedge clk); #1;
    check("y_q_first_edge", y_q, 1'b1);

    // Asynchronous clear between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_y_q", y_q, 1'b0);
    check("async_clear_y", y, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("y_q_recapture", y_q, 1'b1);

    // Clock frozen: y follows i[2], y_q stays put
    @(negedge clk);
    clk_en = 1'b0;
    s = 3'd2;
    i = 8'hFB;
    #3; check("frozen_y_low", y, 1'b0);
    check("frozen_y_q", y_q, 1'b1);
    i = 8'hFF;
    #3; check("frozen_y_high", y, 1'b1);
    i = 8'hFB;
    #3; check("frozen_y_low2", y, 1'b0);
    check("frozen_y_q2", y_q, 1'b1);
    clk_en = 1'b1;

    // Random traffic, with an occasional mid-cycle change before the edge
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      i = 8'($urandom);
      s = 3'($urandom_range(0, 7));
      #1;
      check("rand_y", y, ref_mux(i, s));
      if ($urandom_range(0, 3) == 0) begin
        #2;
        i = 8'($urandom);
        s = 3'($urandom_range(0, 7));
        #1;
        check("rand_y_late", y, ref_mux(i, s));
      end
      exp_q = ref_mux(i, s);
      @(posedge clk); #1;
      check("rand_y_q", y_q, exp_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mux8x1_using_4x1_and_2x1_design
`default_nettype wire
